// File: rtl/wcodec_pkg.sv
// Shared definitions for the weight pixel link codec (encoder and decoder).
//   CODE_ESC / CODE_SOF / CODE_SOL : link escape byte and the two control codes
//   state_e                        : decoder state enum, also exposed for debug
//   PULSE_W                        : width of the sync-pulse down-counter
package wcodec_pkg;

  localparam logic [7:0] CODE_ESC = 8'hFF;
  localparam logic [7:0] CODE_SOF = 8'h00;
  localparam logic [7:0] CODE_SOL = 8'h01;

  localparam int LINE_CNT_W = 12;
  // One extra bit so the saturation value LINE_W+1 is representable for LINE_W=4095.
  localparam int PIX_CNT_W  = 13;
  localparam int PULSE_W    = 16;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_HUNT_ESC,
    ST_VS,
    ST_LINE_WAIT,
    ST_LW_ESC,
    ST_HS,
    ST_DATA,
    ST_DATA_ESC
  } state_e;

endpackage

// File: rtl/wdec_pulse.sv
// Loadable down-counter used to time the vsync and hsync pulse widths.
// One instance is shared: the FSM loads it on entry to VS or HS and leaves
// that state on the cycle last_o is high.
//   clk_i      : clock, rising edge
//   rst_ni     : synchronous active-low reset
//   load_i     : load load_val_i into the counter
//   load_val_i : pulse width in cycles (>=1)
//   last_o     : counter is on its final cycle (value 1)
module wdec_pulse
  import wcodec_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [PULSE_W-1:0] load_val_i,
  output logic               last_o
);

  logic [PULSE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == PULSE_W'(1));

endmodule

// File: rtl/wdecoder.sv
// Receive end of the weight pixel link: decodes the escaped byte stream into
// a pixel bus and flags framing errors.
//   pclk, rst_n : clock and synchronous active-low reset
//   din         : coded link byte, din_valid/din_ready handshake
//   vsync/hsync : frame/line start pulses, VS_W/HS_W cycles wide
//   dout        : decoded pixel, qualified by pix_valid (registered)
//   frame_err   : sticky framing error, cleared by the next good SOF
//   dbg_state   : current FSM state
//
// Handshake: a byte moves when din_valid && din_ready at a rising pclk edge.
// din_ready comes from the state register (and reset) only, never from
// din_valid; the source must hold din stable until it is accepted.
module wdecoder
  import wcodec_pkg::*;
#(
  parameter int LINE_W  = 640,
  parameter int FRAME_H = 480,
  parameter int VS_W    = 4,
  parameter int HS_W    = 2
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       vsync,
  output logic       hsync,
  output logic [7:0] dout,
  output logic       pix_valid,
  output logic       frame_err,
  output state_e     dbg_state
);

  localparam logic [PIX_CNT_W-1:0]  PIX_FULL = PIX_CNT_W'(LINE_W);
  localparam logic [PIX_CNT_W-1:0]  PIX_OVF  = PIX_CNT_W'(LINE_W + 1);
  localparam logic [LINE_CNT_W-1:0] LINES    = LINE_CNT_W'(FRAME_H);

  state_e                  state_q, state_d;
  logic [PIX_CNT_W-1:0]    pix_q, pix_d;
  logic [LINE_CNT_W-1:0]   line_q, line_d;
  logic                    err_q, err_d;
  logic                    pv_q, pv_d;
  logic [7:0]              dout_q, dout_d;

  logic                    accept;
  logic                    emit_req;
  logic                    pulse_load;
  logic [PULSE_W-1:0]      pulse_val;
  logic                    pulse_last;

  wdec_pulse u_pulse (
    .clk_i      (pclk),
    .rst_ni     (rst_n),
    .load_i     (pulse_load),
    .load_val_i (pulse_val),
    .last_o     (pulse_last)
  );

  assign din_ready = rst_n && (state_q != ST_VS) && (state_q != ST_HS);
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    line_d     = line_q;
    err_d      = err_q;
    pv_d       = 1'b0;
    dout_d     = dout_q;
    emit_req   = 1'b0;
    pulse_load = 1'b0;
    pulse_val  = '0;

    case (state_q)
      ST_HUNT: begin
        if (accept && din == CODE_ESC) state_d = ST_HUNT_ESC;
      end
      ST_HUNT_ESC: begin
        if (accept) begin
          if (din == CODE_SOF) begin
            err_d      = 1'b0;
            state_d    = ST_VS;
            pulse_load = 1'b1;
            pulse_val  = PULSE_W'(VS_W);
          end else begin
            // SOL or ESC,ESC here is merely out of sync; any other code is invalid.
            if (din != CODE_SOL && din != CODE_ESC) err_d = 1'b1;
            state_d = ST_HUNT;
          end
        end
      end
      ST_VS: begin
        line_d = '0;
        if (pulse_last) state_d = ST_LINE_WAIT;
      end
      ST_LINE_WAIT: begin
        if (accept) begin
          if (din == CODE_ESC) begin
            state_d = ST_LW_ESC;
          end else begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
          end
        end
      end
      ST_LW_ESC: begin
        if (accept) begin
          if (din == CODE_SOL) begin
            // line_cnt counts lines started in this frame.
            line_d     = line_q + 1'b1;
            state_d    = ST_HS;
            pulse_load = 1'b1;
            pulse_val  = PULSE_W'(HS_W);
          end else begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
          end
        end
      end
      ST_HS: begin
        pix_d = '0;
        if (pulse_last) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (accept) begin
          if (din == CODE_ESC) state_d = ST_DATA_ESC;
          else                 emit_req = 1'b1;
        end
      end
      ST_DATA_ESC: begin
        if (accept) begin
          if (din == CODE_ESC) begin
            emit_req = 1'b1;
            state_d  = ST_DATA;
          end else if (din == CODE_SOL) begin
            if (pix_q != PIX_FULL) err_d = 1'b1;
            if (line_q == LINES) begin
              err_d   = 1'b1;
              state_d = ST_HUNT;
            end else begin
              line_d     = line_q + 1'b1;
              state_d    = ST_HS;
              pulse_load = 1'b1;
              pulse_val  = PULSE_W'(HS_W);
            end
          end else if (din == CODE_SOF) begin
            // A clean frame end clears the error; a bad one keeps it set through VS.
            err_d      = !((pix_q == PIX_FULL) && (line_q == LINES));
            state_d    = ST_VS;
            pulse_load = 1'b1;
            pulse_val  = PULSE_W'(VS_W);
          end else begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // Pixel acceptance: pixels beyond LINE_W are dropped and pix_cnt parks at LINE_W+1.
    if (emit_req) begin
      if (pix_q == PIX_OVF) begin
        err_d = 1'b1;
      end else if (pix_q == PIX_FULL) begin
        err_d = 1'b1;
        pix_d = PIX_OVF;
      end else begin
        pv_d   = 1'b1;
        dout_d = din;
        pix_d  = pix_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
      pix_q   <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
      pv_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      err_q   <= err_d;
      pv_q    <= pv_d;
      dout_q  <= dout_d;
    end
  end

  assign vsync     = (state_q == ST_VS);
  assign hsync     = (state_q == ST_HS);
  assign dout      = dout_q;
  assign pix_valid = pv_q;
  assign frame_err = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wdecoder.sv
module tb_wdecoder;
  import wcodec_pkg::*;

  localparam int LW  = 4;
  localparam int FH  = 2;
  localparam int VSW = 4;
  localparam int HSW = 2;

  logic       pclk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       vsync;
  logic       hsync;
  logic [7:0] dout;
  logic       pix_valid;
  logic       frame_err;
  state_e     dbg_state;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  wdecoder #(.LINE_W(LW), .FRAME_H(FH), .VS_W(VSW), .HS_W(HSW)) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .vsync     (vsync),
    .hsync     (hsync),
    .dout      (dout),
    .pix_valid (pix_valid),
    .frame_err (frame_err),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Driver tasks
  task automatic send(input logic [7:0] b, output int waits);
    waits = 0;
    @(negedge pclk);
    din       = b;
    din_valid = 1'b1;
    while (!din_ready && waits < 64) begin
      @(negedge pclk);
      waits++;
    end
    if (!din_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout byte=%h ready stayed 0 for %0d cycles", b, waits);
      din_valid = 1'b0;
    end else begin
      @(posedge pclk);
      #1 din_valid = 1'b0;
    end
  endtask

  task automatic tx(input logic [7:0] b);
    int w;
    send(b, w);
  endtask

  task automatic pix(input logic [7:0] b);
    exp_q.push_back(b);
    tx(b);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_err(input string name, input logic exp);
    @(negedge pclk);
    check(name, 32'(frame_err), 32'(exp));
  endtask

  // Scoreboard monitor: pixels, sync widths, exclusivity
  int vs_run = 0;
  int hs_run = 0;
  always @(negedge pclk) begin
    if (rst_n) begin
      if (pix_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL pixel_unexpected got=%h expected=none", dout);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (dout !== e) begin
            fails++;
            $display("FAIL pixel got=%h expected=%h", dout, e);
          end
        end
      end
      if ((vsync && hsync) || (pix_valid && (vsync || hsync))) begin
        tests++; fails++;
        $display("FAIL exclusive vs=%b hs=%b pv=%b expected no overlap", vsync, hsync, pix_valid);
      end
      if (vsync) vs_run++;
      else if (vs_run != 0) begin
        tests++;
        if (vs_run != VSW) begin
          fails++;
          $display("FAIL vsync_width got=%0d expected=%0d", vs_run, VSW);
        end
        vs_run = 0;
      end
      if (hsync) hs_run++;
      else if (hs_run != 0) begin
        tests++;
        if (hs_run != HSW) begin
          fails++;
          $display("FAIL hsync_width got=%0d expected=%0d", hs_run, HSW);
        end
        hs_run = 0;
      end
    end
  end

  // Stimulus
  initial begin
    int w;
    rst_n     = 1'b0;
    din       = 8'hFF;
    din_valid = 1'b1;

    // 1. Reset
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check("rst_vsync", 32'(vsync), 0);
    check("rst_hsync", 32'(hsync), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_din_ready", 32'(din_ready), 0);
    din_valid = 1'b0;
    rst_n     = 1'b1;
    #1;
    check("post_rst_ready", 32'(din_ready), 1);
    check("post_rst_state", 32'(dbg_state), 32'(ST_HUNT));

    // 2 + 5. Clean frame; backpressure through VS and HS
    tx(8'hFF); tx(8'h00);
    send(8'hFF, w);
    check("vs_backpressure_waits", w, VSW);
    tx(8'h01);
    exp_q.push_back(8'h11);
    send(8'h11, w);
    check("hs_backpressure_waits", w, HSW);
    @(negedge pclk);
    check("first_pix_after_hs", 32'({pix_valid, dout}), 32'({1'b1, 8'h11}));
    pix(8'h22); pix(8'h33); pix(8'h44);
    tx(8'hFF); tx(8'h01);
    pix(8'h55); pix(8'h66); pix(8'h77); pix(8'h88);
    repeat (2) @(negedge pclk);
    check("dout_hold", 32'({pix_valid, dout}), 32'({1'b0, 8'h88}));
    tx(8'hFF); tx(8'h00);
    check_err("clean_frame_err", 1'b0);

    // 3. Literal escape counts as one pixel
    tx(8'hFF); tx(8'h01);
    pix(8'h11); tx(8'hFF); exp_q.push_back(8'hFF); tx(8'hFF); pix(8'h22); pix(8'h33);
    tx(8'hFF); tx(8'h01);
    check_err("literal_line_len", 1'b0);
    pix(8'h44); pix(8'h55); pix(8'h66); pix(8'h77);
    tx(8'hFF); tx(8'h00);
    check_err("literal_frame_end", 1'b0);

    // 4. Short line, next line still decoded, clean frame clears
    tx(8'hFF); tx(8'h01);
    pix(8'h01); pix(8'h02); pix(8'h03);
    tx(8'hFF); tx(8'h01);
    check_err("short_line_err", 1'b1);
    pix(8'hA1); pix(8'hA2); pix(8'hA3); pix(8'hA4);
    tx(8'hFF); tx(8'h00);
    tx(8'hFF); tx(8'h01);
    pix(8'hB1); pix(8'hB2); pix(8'hB3); pix(8'hB4);
    tx(8'hFF); tx(8'h01);
    pix(8'hC1); pix(8'hC2); pix(8'hC3); pix(8'hC4);
    tx(8'hFF); tx(8'h00);
    check_err("clean_sof_clears", 1'b0);

    // Long line: pixel LINE_W+1 dropped; the failing SOF keeps the error
    tx(8'hFF); tx(8'h01);
    pix(8'hD1); pix(8'hD2); pix(8'hD3); pix(8'hD4);
    tx(8'hD5);
    check_err("long_line_err", 1'b1);
    tx(8'hFF); tx(8'h00);
    check_err("bad_sof_keeps_err", 1'b1);
    tx(8'hFF); tx(8'h01);
    pix(8'h10); pix(8'h20); pix(8'h30); pix(8'h40);
    tx(8'hFF); tx(8'h01);
    pix(8'h50); pix(8'h60); pix(8'h70); pix(8'h80);
    tx(8'hFF); tx(8'h00);
    check_err("next_clean_sof_clears", 1'b0);

    // Extra line: SOL once FRAME_H lines are in -> error, HUNT
    tx(8'hFF); tx(8'h01);
    pix(8'h12); pix(8'h34); pix(8'h56); pix(8'h78);
    tx(8'hFF); tx(8'h01);
    pix(8'h9A); pix(8'hBC); pix(8'hDE); pix(8'hF0);
    tx(8'hFF); tx(8'h01);
    check_err("extra_line_err", 1'b1);
    check("extra_line_state", 32'(dbg_state), 32'(ST_HUNT));
    tx(8'hFF); tx(8'h00);
    check_err("hunt_sof_clears", 1'b0);

    // 6. Bad code mid-line -> error, HUNT, pixels ignored until SOF
    tx(8'hFF); tx(8'h01);
    pix(8'hE1); pix(8'hE2);
    tx(8'hFF); tx(8'h07);
    check_err("bad_code_err", 1'b1);
    check("bad_code_state", 32'(dbg_state), 32'(ST_HUNT));
    tx(8'hF1); tx(8'hF2); tx(8'hFF); tx(8'h01); tx(8'hC7);
    check_err("hunt_err_held", 1'b1);
    tx(8'hFF); tx(8'h00);
    check_err("resync_sof_clears", 1'b0);

    repeat (20) @(negedge pclk);
    check("pixels_outstanding", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
